// File: rtl/axi_lite_rr_arbiter_pkg.sv
// Shared types for the AXI-Lite round-robin arbiter.
// The state enum is also used by the bridge for debug visibility.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_lite_rr_arbiter_if.sv
// Arbiter control bundle for one AXI-Lite channel direction.
//   req         : per-master request (aw_valid / ar_valid)
//   addr_hs     : address handshake done at the slave side
//   resp_hs     : response handshake done on the granted master
//   grant       : one-hot grant
//   grant_idx   : binary index of the granted master
//   grant_valid : grant / grant_idx are meaningful
//   addr_phase  : address phase open; gates forwarding of master valids
//   timeout     : one-cycle watchdog expiry pulse
// master = requester/bridge side, slave = arbiter side.
interface axi_lite_rr_arbiter_if #(
  parameter int unsigned N = 4
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  req;
  logic          addr_hs;
  logic          resp_hs;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          addr_phase;
  logic          timeout;

  modport master (
    output req, addr_hs, resp_hs,
    input  grant, grant_idx, grant_valid, addr_phase, timeout
  );

  modport slave (
    input  req, addr_hs, resp_hs,
    output grant, grant_idx, grant_valid, addr_phase, timeout
  );

endinterface

// File: rtl/axi_lite_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req scanning upward
// from ptr, wrapping N-1 -> 0.
//   req      : request vector
//   ptr      : scan start position
//   pick     : one-hot winner (zero when no request)
//   pick_idx : binary index of the winner
//   any      : at least one request present
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] pick_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]   upper;
  logic [2*N-1:0] dbl;
  logic           found;

  // Low half holds requesters at or above ptr, high half the full vector,
  // so the lowest set bit of the doubled word is the wrapped winner.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    upper    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      upper[i] = req[i] && (IW'(i) >= ptr);
    end
    dbl = {req, upper};
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (!found && dbl[i]) begin
        found    = 1'b1;
        pick_idx = (i < N) ? IW'(i) : IW'(i - N);
      end
    end
    any = |req;
    if (any) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Transaction-level round-robin arbiter/sequencer for one AXI-Lite channel
// direction, with a response watchdog.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : arbiter control bundle (slave modport), see axi_lite_rr_arbiter_if
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_rr_arbiter_if.slave  bus
);

  localparam int unsigned   IW       = $clog2(N);
  localparam int unsigned   CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST  = (TIMEOUT == 0) ? CW'(0) : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WD_SAT   = CW'(TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          gv_q, ap_q;
  logic          to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          resp_evt;
  logic [IW-1:0] ptr_adv;
  logic [IW-1:0] pick_ptr;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  // A response completes in BUSY, or in GRANT when addr and resp coincide.
  assign resp_evt = bus.resp_hs &&
                    ((state_q == BUSY) || ((state_q == GRANT) && bus.addr_hs));
  assign ptr_adv  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  // Re-arbitration after a response uses the already-advanced pointer.
  assign pick_ptr = resp_evt ? ptr_adv : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req      (bus.req),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Next-state, grant and watchdog logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick;
          idx_d   = pick_idx;
        end
      end
      GRANT: begin
        if (bus.addr_hs && !bus.resp_hs) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // Counter saturates one past the expiry value so the pulse is single.
        if (!bus.resp_hs && (TIMEOUT != 0)) begin
          if (cnt_q == WD_LAST) to_d = 1'b1;
          if (cnt_q != WD_SAT) cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (resp_evt) begin
      ptr_d = ptr_adv;
      if (pick_any) begin
        state_d = GRANT;
        grant_d = pick;
        idx_d   = pick_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      gv_q    <= 1'b0;
      ap_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      gv_q    <= (state_d != IDLE);
      ap_q    <= (state_d == GRANT);
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = gv_q;
  assign bus.addr_phase  = ap_q;
  assign bus.timeout     = to_q;

endmodule

// File: doc/axi_lite_rr_arbiter.md
# axi_lite_rr_arbiter

Transaction-level round-robin arbiter and sequencer for one AXI-Lite channel direction (write AW/W/B or read AR/R) shared by N masters in front of a single slave. It owns the grant from arbitration through the response handshake, so the bridge datapath only steers muxes from `grant_idx`. It also runs a response watchdog. Two instances sit inside the Nx1 bridge: one for writes, one for reads.

## Interface
Parameters:
- `N`, 4: number of requesting masters, 2..16.
- `TIMEOUT`, 256: cycles allowed in BUSY before `timeout` pulses; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-master request: aw_valid (write instance) or ar_valid (read instance).
- `addr_hs`  in  1  address handshake completed at the slave side; for writes, AW and W both accepted.
- `resp_hs`  in  1  response handshake completed on the granted master (b_valid&b_ready or r_valid&r_ready).
- `grant`  out  N  one-hot grant, registered.
- `grant_idx`  out  $clog2(N)  binary index of the granted master, registered.
- `grant_valid`  out  1  grant and grant_idx are meaningful.
- `addr_phase`  out  1  high in GRANT; the datapath forwards the granted master's valid signals only while this is high.
- `timeout`  out  1  one-cycle pulse when the BUSY watchdog expires.

## Operation
- States: IDLE, GRANT (address phase open), BUSY (waiting for response).
- IDLE: if `req` != 0, pick a master, go to GRANT. Otherwise stay in IDLE.
- GRANT: hold the grant. On `addr_hs`, go to BUSY.
- BUSY: on `resp_hs`:
  - Advance the pointer to grant_idx+1 mod N.
  - Re-arbitrate in the same cycle using the updated pointer and current `req`.
  - If a requester exists, go to GRANT with the new grant. Otherwise go to IDLE.
- `addr_hs` and `resp_hs` in the same GRANT cycle: treated as addr then resp; follow the BUSY rule in that cycle.
- Pick rule: the first set bit of `req`, scanning upward from the pointer, wrapping at N-1 -> 0. The pointer resets to 0.
- The grant never changes between GRANT entry and `resp_hs`, even if `req` of the grantee drops (protocol violation, ignored).
- `addr_hs` outside GRANT and `resp_hs` outside BUSY are ignored.
- Watchdog:
  - The counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT-1, `timeout` pulses once and the counter saturates.
  - The state remains BUSY; recovery is by `rst` only.
- Fairness: a continuously requesting master is granted within N transactions.

## Timing
- Reset values:
  - state = IDLE, pointer = 0.
  - grant = 0, grant_idx = 0, grant_valid = 0, addr_phase = 0, timeout = 0.
  - Watchdog counter = 0.
- Arbitration latency from IDLE: `req` rising in cycle t gives grant_valid=1 in t+1.
- Back-to-back: `resp_hs` in cycle t gives the next grant in t+1. There is no idle bubble.
- `addr_phase` falls the cycle after `addr_hs`.
- `grant_valid` is high in GRANT and BUSY and low only in IDLE.
- Reset mid-transaction: any state returns to IDLE next cycle and the pointer clears. No partial response is tracked.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `axi_lite_pkg`: `arb_state_e` enum (IDLE, GRANT, BUSY). Shared with the bridge for debug visibility.
- Sub-module `rr_pick`: combinational. Inputs are `req` and the pointer; outputs are a one-hot pick, its index, and `any`. Implemented as a double-width mask/priority scan. Reused by both instances.
- Top level contains the FSM, pointer register, grant registers, and watchdog counter of width $clog2(TIMEOUT+1).

## Test plan
Scenarios use N=4, TIMEOUT=16.
- Single requester: req=0100 at t. At t+1, grant=0100, idx=2, addr_phase=1. `addr_hs` at t+3 gives addr_phase=0 at t+4. `resp_hs` at t+6 gives grant_valid=0 at t+7.
- Full contention: req=1111 held, with each transaction taking one `addr_hs` and one `resp_hs`. Grant order is 0,1,2,3,0, with no idle cycle between transactions.
- Wrap and skip: pointer=3 (after serving master 2) and req=0011 give idx=0, then idx=1.
- Grant stability: master 1 granted, then req changes to 1001 mid-BUSY. grant stays 0010 until `resp_hs`, then moves to idx=3.
- Watchdog: hold BUSY 20 cycles with no `resp_hs`. `timeout` pulses exactly once, 16 cycles after BUSY entry, and the state stays BUSY.
- Reset in BUSY: assert rst for 1 cycle with grant=1000. Next cycle all outputs are 0. A subsequent req=1111 grants idx=0.
